// File: rtl/poly_horner_pkg.sv
// Shared constants for the Horner polynomial evaluator: FSM state encodings
// and the coefficient-index width helper.
package poly_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_ADD  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Bits needed to index n coefficients; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/poly_horner_if.sv
// Start/done request bus between the operand registers and poly_horner.
interface poly_horner_if #(
   parameter int W      = 16,
   parameter int DEGREE = 2
);
   logic                      start;
   logic [W-1:0]              x;
   logic [(DEGREE+1)*W-1:0]   coef;
   logic                      busy;
   logic                      done;
   logic [W-1:0]              result;
   logic                      overflow;

   modport master (
      output start, x, coef,
      input  busy, done, result, overflow
   );

   modport slave (
      input  start, x, coef,
      output busy, done, result, overflow
   );
endinterface

// File: rtl/poly_horner_ctrl.sv
// Sequencer for poly_horner: IDLE/MUL/ADD/DONE FSM plus the coefficient
// index k, emitting datapath enables and the registered busy/done flags.
module poly_horner_ctrl
   import poly_pkg::*;
#(
   parameter int DEGREE = 2,
   parameter int KW     = idx_w(DEGREE + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          load,
   output logic          mul_en,
   output logic          add_en,
   output logic          busy,
   output logic          done,
   output logic [KW-1:0] k
);

   logic [1:0] state;
   logic [1:0] state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_MUL;
         ST_MUL:  state_nxt = ST_ADD;
         ST_ADD:  state_nxt = (k == '0) ? ST_DONE : ST_MUL;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign load   = (state == ST_IDLE) && start;
   assign mul_en = (state == ST_MUL);
   assign add_en = (state == ST_ADD);

   // busy/done are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         k     <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != ST_IDLE);
         done  <= (state_nxt == ST_DONE);
         if (load)
            k <= KW'(DEGREE - 1);
         else if (add_en && (k != '0))
            k <= k - 1'b1;
      end
   end

endmodule

// File: rtl/poly_horner.sv
// Parametrised polynomial evaluator using Horner's rule on a shared
// multiply/add datapath; sequencing lives in poly_horner_ctrl.
module poly_horner
   import poly_pkg::*;
#(
   parameter int W      = 16,
   parameter int DEGREE = 2
) (
   input  logic         clk,
   input  logic         rst,
   poly_horner_if.slave bus
);

   localparam int KW = idx_w(DEGREE + 1);

   logic          load;
   logic          mul_en;
   logic          add_en;
   logic [KW-1:0] k;
   logic [W-1:0]  x_r;
   logic [W-1:0]  cbank [DEGREE+1];
   logic [W-1:0]  acc;
   logic [W-1:0]  prod;
   logic [W-1:0]  c_k;
   logic          ovf;
   logic [2*W-1:0] prod_full;
   logic [W:0]    sum;

   function automatic logic [2*W-1:0] mul_wide(input logic [W-1:0] a, input logic [W-1:0] b);
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
   endfunction

   function automatic logic [W:0] add_carry(input logic [W-1:0] a, input logic [W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   poly_horner_ctrl #(
      .DEGREE (DEGREE),
      .KW     (KW)
   ) u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .start  (bus.start),
      .load   (load),
      .mul_en (mul_en),
      .add_en (add_en),
      .busy   (bus.busy),
      .done   (bus.done),
      .k      (k)
   );

   assign c_k       = cbank[k];
   assign prod_full = mul_wide(acc, x_r);
   assign sum       = add_carry(prod, c_k);

   // Operands are captured once on accept so the caller may change them freely.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r  <= '0;
         acc  <= '0;
         prod <= '0;
         ovf  <= 1'b0;
         for (int i = 0; i <= DEGREE; i++)
            cbank[i] <= '0;
      end else if (load) begin
         x_r <= bus.x;
         for (int i = 0; i <= DEGREE; i++)
            cbank[i] <= bus.coef[i*W +: W];
         acc <= bus.coef[DEGREE*W +: W];
         ovf <= 1'b0;
      end else if (mul_en) begin
         prod <= prod_full[W-1:0];
         if (|prod_full[2*W-1:W])
            ovf <= 1'b1;
      end else if (add_en) begin
         acc <= sum[W-1:0];
         if (sum[W])
            ovf <= 1'b1;
      end
   end

   assign bus.result   = acc;
   assign bus.overflow = ovf;

endmodule

// File: tb/tb_poly_horner.sv
// Self-checking bench for poly_horner: a 16-bit quadratic instance and an
// 8-bit cubic instance, with a scoreboard of expected results.
module tb_poly_horner;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   poly_horner_if #(.W(16), .DEGREE(2)) bus16 ();
   poly_horner_if #(.W(8),  .DEGREE(3)) bus8 ();

   poly_horner #(.W(16), .DEGREE(2)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   poly_horner #(.W(8), .DEGREE(3)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   typedef struct {
      logic [15:0] res;
      logic        ovf;
      int          edges;
      string       name;
   } exp_t;

   typedef struct {
      logic [15:0] x;
      logic [47:0] coef;
      logic [15:0] res;
      logic        ovf;
      string       name;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[5];
   int   checks = 0;
   int   errors = 0;

   function automatic logic cur_done(input bit sel);
      return sel ? bus8.done : bus16.done;
   endfunction

   function automatic logic cur_busy(input bit sel);
      return sel ? bus8.busy : bus16.busy;
   endfunction

   function automatic logic cur_ovf(input bit sel);
      return sel ? bus8.overflow : bus16.overflow;
   endfunction

   function automatic logic [15:0] cur_res(input bit sel);
      return sel ? {8'h00, bus8.result} : bus16.result;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Called at the falling edge in IDLE; returns at the falling edge after acceptance.
   task automatic start16(input logic [15:0] xv, input logic [47:0] cv,
                          input logic [15:0] er, input logic eo, input string name);
      bus16.x     = xv;
      bus16.coef  = cv;
      bus16.start = 1'b1;
      sb.push_back(exp_t'{er, eo, 4, name});
      @(negedge clk);
      bus16.start = 1'b0;
   endtask

   task automatic start8(input logic [7:0] xv, input logic [31:0] cv,
                         input logic [7:0] er, input logic eo, input string name);
      bus8.x     = xv;
      bus8.coef  = cv;
      bus8.start = 1'b1;
      sb.push_back(exp_t'{{8'h00, er}, eo, 6, name});
      @(negedge clk);
      bus8.start = 1'b0;
   endtask

   // Entered at the falling edge just after the accepting edge.
   task automatic wait_done(input bit sel);
      exp_t ex;
      int   e;
      int   bc;
      e  = 1;
      bc = 0;
      while (!cur_done(sel) && e < 40) begin
         if (cur_busy(sel)) bc++;
         @(negedge clk);
         e++;
      end
      ex = sb.pop_front();
      chk({ex.name, "_done"}, 32'(cur_done(sel)), 32'd1);
      if (!cur_done(sel)) return;
      if (cur_busy(sel)) bc++;
      chk({ex.name, "_latency"}, 32'(e - 1), 32'(ex.edges));
      chk({ex.name, "_result"}, 32'(cur_res(sel)), 32'(ex.res));
      chk({ex.name, "_ovf"}, 32'(cur_ovf(sel)), 32'(ex.ovf));
      chk({ex.name, "_busycyc"}, 32'(bc), 32'(ex.edges + 1));
      @(negedge clk);
      chk({ex.name, "_idle"}, {30'd0, cur_busy(sel), cur_done(sel)}, 32'd0);
      chk({ex.name, "_held"}, 32'(cur_res(sel)), 32'(ex.res));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      bus16.start = 1'b0;
      bus16.x     = '0;
      bus16.coef  = '0;
      bus8.start  = 1'b0;
      bus8.x      = '0;
      bus8.coef   = '0;

      tbl[0] = '{16'd5,   {16'd3, 16'd2, 16'd1},          16'd86,    1'b0, "basic"};
      tbl[1] = '{16'd300, {16'd1, 16'd0, 16'd0},          16'd24464, 1'b1, "mulovf"};
      tbl[2] = '{16'd2,   {16'd1, 16'd0, 16'd0},          16'd4,     1'b0, "ovfclr"};
      tbl[3] = '{16'd0,   {16'd7, 16'd9, 16'h1234},       16'h1234,  1'b0, "xzero"};
      tbl[4] = '{16'd1,   {16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'hFFFD,  1'b1, "carry"};

      repeat (2) @(negedge clk);
      chk("rst_res16", 32'(bus16.result), 32'd0);
      chk("rst_flags16", {29'd0, bus16.busy, bus16.done, bus16.overflow}, 32'd0);
      chk("rst_res8", 32'(bus8.result), 32'd0);
      chk("rst_flags8", {29'd0, bus8.busy, bus8.done, bus8.overflow}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         start16(tbl[i].x, tbl[i].coef, tbl[i].res, tbl[i].ovf, tbl[i].name);
         wait_done(1'b0);
      end

      // start held high; operands changed after the first capture
      bus16.x     = 16'd5;
      bus16.coef  = {16'd3, 16'd2, 16'd1};
      bus16.start = 1'b1;
      sb.push_back(exp_t'{16'd86, 1'b0, 4, "hold1"});
      @(negedge clk);
      bus16.x    = 16'd2;
      bus16.coef = {16'd1, 16'd1, 16'd1};
      sb.push_back(exp_t'{16'd7, 1'b0, 4, "hold2"});
      wait_done(1'b0);
      @(negedge clk);
      bus16.start = 1'b0;
      wait_done(1'b0);

      // reset asserted while in ADD
      start16(16'd5, {16'd3, 16'd2, 16'd1}, 16'd86, 1'b0, "rstmid");
      @(negedge clk);
      chk("rstmid_busy_before", 32'(bus16.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      chk("rstmid_res", 32'(bus16.result), 32'd0);
      chk("rstmid_flags", {29'd0, bus16.busy, bus16.done, bus16.overflow}, 32'd0);
      @(negedge clk);
      chk("rstmid_stay_idle", {30'd0, bus16.busy, bus16.done}, 32'd0);
      start16(16'd5, {16'd3, 16'd2, 16'd1}, 16'd86, 1'b0, "after_rst");
      wait_done(1'b0);

      // cubic, 8-bit instance
      start8(8'd2, {8'd1, 8'd1, 8'd1, 8'd1}, 8'd15, 1'b0, "deg3");
      wait_done(1'b1);
      start8(8'd16, {8'd1, 8'd0, 8'd0, 8'd0}, 8'd0, 1'b1, "deg3ovf");
      wait_done(1'b1);
      start8(8'd3, {8'd2, 8'd0, 8'd1, 8'd5}, 8'd62, 1'b0, "deg3mix");
      wait_done(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
